// File: rtl/updn_cmd_conditioner_if.sv
// Command bus from the button conditioner to the 5-bit up/down counter.
// The conditioner drives the bus (master); the counter consumes it (slave).
interface updn_cmd_conditioner_if;
    logic       up_pulse;
    logic       dn_pulse;
    logic       load_pulse;
    logic [4:0] load_val;

    modport master (
        output up_pulse,
        output dn_pulse,
        output load_pulse,
        output load_val
    );

    modport slave (
        input up_pulse,
        input dn_pulse,
        input load_pulse,
        input load_val
    );
endinterface

// File: rtl/updn_cmd_conditioner.sv
// Conditions three raw pushbuttons and a slide-switch bank into one-cycle
// commands for a 5-bit up/down counter. Each input is synchronized, each
// button is debounced independently, debounced presses latch a pending bit,
// and a fixed-priority arbiter (load > down > up) issues at most one
// registered command per cycle.
module updn_cmd_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          btn_up_raw,
    input  logic                          btn_dn_raw,
    input  logic                          btn_load_raw,
    input  logic [4:0]                    sw_in,
    updn_cmd_conditioner_if.master        cmd
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button bit order everywhere: [0] up, [1] down, [2] load.
    logic [2:0]            btn_meta;
    logic [2:0]            btn_sync;
    logic [4:0]            sw_meta;
    logic [4:0]            sw_sync;
    logic [2:0]            deb;
    logic [2:0][CNT_W-1:0] cnt;
    logic [2:0]            rise;
    logic [2:0]            pend;
    logic [2:0]            grant;

    // Two-flop synchronizers for all asynchronous inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= '0;
            btn_sync <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            btn_meta <= {btn_load_raw, btn_dn_raw, btn_up_raw};
            btn_sync <= btn_meta;
            sw_meta  <= sw_in;
            sw_sync  <= sw_meta;
        end
    end

    // Per-button debouncer: accept a new level after DEBOUNCE_CYCLES
    // consecutive differing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= '0;
            cnt <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (btn_sync[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= btn_sync[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Debounced 0->1 transition, taking effect on the same edge as the level update.
    always_comb begin
        rise = '0;
        for (int i = 0; i < 3; i++) begin
            rise[i] = btn_sync[i] && !deb[i] && (cnt[i] == CNT_LAST);
        end
    end

    // Fixed-priority grant from the registered pending bits only, so a bit
    // can never be set and issued on the same edge.
    always_comb begin
        grant = 3'b000;
        if (pend[2]) begin
            grant = 3'b100;
        end else if (pend[1]) begin
            grant = 3'b010;
        end else if (pend[0]) begin
            grant = 3'b001;
        end
    end

    // Pending bits: set by a debounced press (merging repeats), cleared on issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~grant) | rise;
        end
    end

    // Registered command outputs; load_val captures the switches only on a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd.up_pulse   <= 1'b0;
            cmd.dn_pulse   <= 1'b0;
            cmd.load_pulse <= 1'b0;
            cmd.load_val   <= '0;
        end else begin
            cmd.up_pulse   <= grant[0];
            cmd.dn_pulse   <= grant[1];
            cmd.load_pulse <= grant[2];
            if (grant[2]) begin
                cmd.load_val <= sw_sync;
            end
        end
    end

endmodule

// File: tb/tb_updn_cmd_conditioner.sv
// Directed bench for updn_cmd_conditioner with DEBOUNCE_CYCLES = 4.
// Inputs change 1 time unit after a rising edge ("edge 0"); edges are then
// counted from 1 and outputs are sampled 1 time unit after each edge.
module tb_updn_cmd_conditioner;

    logic       clk;
    logic       rst_n;
    logic       btn_up_raw;
    logic       btn_dn_raw;
    logic       btn_load_raw;
    logic [4:0] sw_in;

    updn_cmd_conditioner_if cmd ();

    updn_cmd_conditioner #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_up_raw   (btn_up_raw),
        .btn_dn_raw   (btn_dn_raw),
        .btn_load_raw (btn_load_raw),
        .sw_in        (sw_in),
        .cmd          (cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observation state accumulated by run().
    int         edge_n;
    int         up_cnt, dn_cnt, ld_cnt, multi_cnt;
    int         up_first, up_last, dn_first, ld_first;
    logic [4:0] ld_val;
    bit         deb_up_seen;

    task automatic clear_obs();
        edge_n      = 0;
        up_cnt      = 0;
        dn_cnt      = 0;
        ld_cnt      = 0;
        multi_cnt   = 0;
        up_first    = -1;
        up_last     = -1;
        dn_first    = -1;
        ld_first    = -1;
        ld_val      = '0;
        deb_up_seen = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            edge_n++;
            if (dut.deb[0]) deb_up_seen = 1'b1;
            if ((int'(cmd.up_pulse) + int'(cmd.dn_pulse) + int'(cmd.load_pulse)) > 1) multi_cnt++;
            if (cmd.up_pulse) begin
                up_cnt++;
                if (up_first < 0) up_first = edge_n;
                up_last = edge_n;
            end
            if (cmd.dn_pulse) begin
                dn_cnt++;
                if (dn_first < 0) dn_first = edge_n;
            end
            if (cmd.load_pulse) begin
                ld_cnt++;
                if (ld_first < 0) ld_first = edge_n;
                ld_val = cmd.load_val;
            end
        end
    endtask

    task automatic do_reset();
        btn_up_raw   = 1'b0;
        btn_dn_raw   = 1'b0;
        btn_load_raw = 1'b0;
        sw_in        = '0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_obs();
    endtask

    task automatic test_reset();
        btn_up_raw   = 1'b0;
        btn_dn_raw   = 1'b0;
        btn_load_raw = 1'b0;
        sw_in        = 5'd31;
        rst_n        = 1'b0;
        #2;
        checks++;
        if (cmd.up_pulse !== 1'b0) begin errors++; $display("FAIL reset_up: got %b expected 0", cmd.up_pulse); end
        checks++;
        if (cmd.dn_pulse !== 1'b0) begin errors++; $display("FAIL reset_dn: got %b expected 0", cmd.dn_pulse); end
        checks++;
        if (cmd.load_pulse !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", cmd.load_pulse); end
        checks++;
        if (cmd.load_val !== 5'd0) begin errors++; $display("FAIL reset_load_val: got %0d expected 0", cmd.load_val); end
    endtask

    task automatic test_clean_up();
        do_reset();
        btn_up_raw = 1'b1;
        run(20);
        btn_up_raw = 1'b0;
        run(10);
        checks++;
        if (up_cnt != 1) begin errors++; $display("FAIL clean_up_count: got %0d expected 1", up_cnt); end
        checks++;
        if (up_first != 7) begin errors++; $display("FAIL clean_up_edge: got %0d expected 7", up_first); end
        checks++;
        if (dn_cnt != 0) begin errors++; $display("FAIL clean_up_dn: got %0d expected 0", dn_cnt); end
        checks++;
        if (ld_cnt != 0) begin errors++; $display("FAIL clean_up_load: got %0d expected 0", ld_cnt); end
    endtask

    task automatic test_bounce_dn();
        do_reset();
        btn_dn_raw = 1'b1; run(1);
        btn_dn_raw = 1'b0; run(1);
        btn_dn_raw = 1'b1; run(1);
        btn_dn_raw = 1'b0; run(1);
        btn_dn_raw = 1'b1;
        run(16);
        btn_dn_raw = 1'b0;
        run(8);
        checks++;
        if (dn_cnt != 1) begin errors++; $display("FAIL bounce_dn_count: got %0d expected 1", dn_cnt); end
        checks++;
        if (dn_first != 11) begin errors++; $display("FAIL bounce_dn_edge: got %0d expected 11", dn_first); end
    endtask

    task automatic test_priority();
        do_reset();
        sw_in        = 5'd19;
        btn_up_raw   = 1'b1;
        btn_dn_raw   = 1'b1;
        btn_load_raw = 1'b1;
        run(14);
        sw_in = 5'd3;
        run(4);
        checks++;
        if (ld_first != 7) begin errors++; $display("FAIL prio_load_edge: got %0d expected 7", ld_first); end
        checks++;
        if (ld_val !== 5'd19) begin errors++; $display("FAIL prio_load_val: got %0d expected 19", ld_val); end
        checks++;
        if (dn_first != 8) begin errors++; $display("FAIL prio_dn_edge: got %0d expected 8", dn_first); end
        checks++;
        if (up_first != 9) begin errors++; $display("FAIL prio_up_edge: got %0d expected 9", up_first); end
        checks++;
        if (ld_cnt != 1 || dn_cnt != 1 || up_cnt != 1) begin
            errors++;
            $display("FAIL prio_counts: got load=%0d dn=%0d up=%0d expected 1 each", ld_cnt, dn_cnt, up_cnt);
        end
        checks++;
        if (multi_cnt != 0) begin errors++; $display("FAIL prio_one_per_cycle: got %0d multi-pulse cycles expected 0", multi_cnt); end
        checks++;
        if (cmd.load_val !== 5'd19) begin errors++; $display("FAIL prio_load_val_held: got %0d expected 19", cmd.load_val); end
        btn_up_raw   = 1'b0;
        btn_dn_raw   = 1'b0;
        btn_load_raw = 1'b0;
    endtask

    task automatic test_glitch();
        do_reset();
        btn_up_raw = 1'b1;
        run(3);
        btn_up_raw = 1'b0;
        run(15);
        checks++;
        if (up_cnt != 0) begin errors++; $display("FAIL glitch_pulse: got %0d expected 0", up_cnt); end
        checks++;
        if (deb_up_seen !== 1'b0) begin errors++; $display("FAIL glitch_debounced: got %b expected 0", deb_up_seen); end
    endtask

    task automatic test_reset_mid_pending();
        do_reset();
        sw_in        = 5'd22;
        btn_dn_raw   = 1'b1;
        btn_load_raw = 1'b1;
        run(7);
        checks++;
        if (cmd.load_pulse !== 1'b1) begin errors++; $display("FAIL midrst_pre_load: got %b expected 1", cmd.load_pulse); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cmd.load_pulse !== 1'b0 || cmd.dn_pulse !== 1'b0 || cmd.up_pulse !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pulses: got up=%b dn=%b load=%b expected 0", cmd.up_pulse, cmd.dn_pulse, cmd.load_pulse);
        end
        checks++;
        if (cmd.load_val !== 5'd0) begin errors++; $display("FAIL midrst_load_val: got %0d expected 0", cmd.load_val); end
        checks++;
        if (dut.pend !== 3'b000) begin errors++; $display("FAIL midrst_pending: got %b expected 000", dut.pend); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_obs();
        run(14);
        checks++;
        if (ld_first != 7) begin errors++; $display("FAIL midrst_load_edge: got %0d expected 7", ld_first); end
        checks++;
        if (ld_cnt != 1) begin errors++; $display("FAIL midrst_load_count: got %0d expected 1", ld_cnt); end
        checks++;
        if (ld_val !== 5'd22) begin errors++; $display("FAIL midrst_load_val_after: got %0d expected 22", ld_val); end
        checks++;
        if (dn_first != 8) begin errors++; $display("FAIL midrst_dn_edge: got %0d expected 8", dn_first); end
        btn_dn_raw   = 1'b0;
        btn_load_raw = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        btn_up_raw = 1'b1; run(10);
        btn_up_raw = 1'b0; run(10);
        btn_up_raw = 1'b1; run(10);
        btn_up_raw = 1'b0; run(12);
        checks++;
        if (up_cnt != 2) begin errors++; $display("FAIL repeat_count: got %0d expected 2", up_cnt); end
        checks++;
        if (up_first != 7) begin errors++; $display("FAIL repeat_first_edge: got %0d expected 7", up_first); end
        checks++;
        if (up_last != 27) begin errors++; $display("FAIL repeat_second_edge: got %0d expected 27", up_last); end
        checks++;
        if (dn_cnt != 0 || ld_cnt != 0) begin errors++; $display("FAIL repeat_other: got dn=%0d load=%0d expected 0", dn_cnt, ld_cnt); end
    endtask

    initial begin
        clear_obs();
        test_reset();
        test_clean_up();
        test_bounce_dn();
        test_priority();
        test_glitch();
        test_reset_mid_pending();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
